// File: rtl/alu_mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mult_sequencer
//  Brief    : Shift-add unsigned multiplier that borrows the shared ALU adder,
//             one add per multiplier bit, with a fixed data-independent latency.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_mult_sequencer #(
    parameter int WIDTH   = 64,
    parameter int ALU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [2:0]           alu_cntrl,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_carry_out
);

    localparam int c_ITER_W = $clog2(WIDTH + 1);
    localparam int c_SET_W  = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    localparam logic [c_ITER_W-1:0] c_LAST_ITER   = c_ITER_W'(WIDTH - 1);
    localparam logic [c_SET_W-1:0]  c_LAST_SETTLE = c_SET_W'(ALU_LAT - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [2:0] c_OP_PASS_B = 3'b000;
    localparam logic [2:0] c_OP_ADD    = 3'b010;

    logic [1:0]           r_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [c_ITER_W-1:0]  r_iter;
    logic [c_SET_W-1:0]   r_settle;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_calc;
    logic                 w_sample;

    assign w_calc   = (r_state == c_CALC);
    assign w_sample = w_calc && (r_settle == c_LAST_SETTLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_mcand   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_iter    <= '0;
            r_settle  <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_mcand  <= multiplicand;
                        r_hi     <= '0;
                        r_lo     <= multiplier;
                        r_iter   <= '0;
                        r_settle <= '0;
                        r_state  <= c_CALC;
                    end
                end
                c_CALC: begin
                    if (w_sample) begin
                        // Carry becomes the new MSB of hi: the partial sum is WIDTH+1 bits.
                        r_hi     <= {alu_carry_out, alu_result[WIDTH-1:1]};
                        r_lo     <= {alu_result[0], r_lo[WIDTH-1:1]};
                        r_settle <= '0;
                        r_iter   <= r_iter + c_ITER_W'(1);
                        if (r_iter == c_LAST_ITER) begin
                            r_product <= {alu_carry_out, alu_result, r_lo[WIDTH-1:1]};
                            r_state   <= c_DONE;
                        end
                    end else begin
                        r_settle <= r_settle + c_SET_W'(1);
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy      = w_calc;
    assign done      = (r_state == c_DONE);
    assign product   = r_product;
    assign alu_cntrl = w_calc ? c_OP_ADD : c_OP_PASS_B;
    assign alu_a     = w_calc ? r_hi : '0;
    assign alu_b     = (w_calc && r_lo[0]) ? r_mcand : '0;

endmodule
`default_nettype wire
